relm_ps2_ctrl: RTL and testbench

- Hardware PS/2 host controller that replaces software bit-banging of the ps2 pins behind the ReLM push/pop I/O ports.
- Receives device frames into a small scancode FIFO and serialises host-to-device command bytes, including the inhibit and request-to-send sequence.
- Exposes one push port (TX byte) and one pop port (RX byte plus status) in the standard [WD:0] strobe/retry format.

---
 rtl/relm_ps2_ctrl_if.sv | 23 ++
 rtl/relm_ps2_ctrl.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_relm_ps2_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/relm_ps2_ctrl_if.sv
// Push/pop I/O port bundle of the ReLM PS/2 host controller ([WD] strobe/retry word format).
interface relm_ps2_ctrl_if #(
    parameter int unsigned WD = 32
);
    logic [WD:0] push_d;
    logic        push_retry;
    logic [WD:0] pop_d;
    logic [WD:0] pop_q;

    modport master (
        output push_d,
        output pop_d,
        input  push_retry,
        input  pop_q
    );

    modport slave (
        input  push_d,
        input  pop_d,
        output push_retry,
        output pop_q
    );
endinterface

// File: rtl/relm_ps2_ctrl.sv
// PS/2 host controller: filtered RX into a scancode FIFO, host-to-device TX with inhibit/RTS.
// Host-to-device path is built only when RELM_PS2_TX_EN is defined.
module relm_ps2_ctrl #(
    parameter int unsigned WD          = 32,
    parameter int unsigned FILTER      = 8,
    parameter int unsigned WAF         = 4,
    parameter int unsigned INHIBIT_CYC = 5000,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ps2_clk_in,
    input  logic            ps2_dat_in,
    output logic            ps2_clk_oe_out,
    output logic            ps2_dat_oe_out,
    relm_ps2_ctrl_if.slave  io
);

    localparam int unsigned CntMax = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned Depth  = 1 << WAF;

    typedef enum logic [2:0] {
        StIdle,
        StRx,
        StTxInhibit,
        StTx,
        StTxAck
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers and glitch filters
    // ------------------------------------------------------------------
    logic [1:0]        clk_sync_q, dat_sync_q;
    logic [FILTER-1:0] clk_sh_q, dat_sh_q;
    logic              clk_f_q, dat_f_q;
    logic              fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_sh_q   <= '1;
            dat_sh_q   <= '1;
            clk_f_q    <= 1'b1;
            dat_f_q    <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            clk_sh_q   <= (clk_sh_q << 1) | FILTER'(clk_sync_q[1]);
            dat_sh_q   <= (dat_sh_q << 1) | FILTER'(dat_sync_q[1]);
            if (clk_sh_q == '0) begin
                clk_f_q <= 1'b0;
            end else if (&clk_sh_q) begin
                clk_f_q <= 1'b1;
            end
            if (dat_sh_q == '0) begin
                dat_f_q <= 1'b0;
            end else if (&dat_sh_q) begin
                dat_f_q <= 1'b1;
            end
        end
    end

    // Pulses in the cycle the filtered clock is about to drop.
    assign fall = clk_f_q & (clk_sh_q == '0);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic [8:0]      rx_sh_q, rx_sh_d;
    logic            rx_ok, set_err, timeout;

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYC));

`ifdef RELM_PS2_TX_EN
    logic [9:0] tx_sh_q, tx_sh_d;
    logic       clk_oe_q, clk_oe_d;
    logic       dat_oe_q, dat_oe_d;
    logic       push_acc;

    assign push_acc = io.push_d[WD] & (state_q == StIdle) & ~fall;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        rx_sh_d = rx_sh_q;
        rx_ok   = 1'b0;
        set_err = 1'b0;
`ifdef RELM_PS2_TX_EN
        tx_sh_d  = tx_sh_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall && !dat_f_q) begin
                    state_d = StRx;
                    bcnt_d  = '0;
                end
`ifdef RELM_PS2_TX_EN
                else if (push_acc) begin
                    tx_sh_d  = {1'b1, ~^io.push_d[7:0], io.push_d[7:0]};
                    clk_oe_d = 1'b1;
                    cnt_d    = CntW'(INHIBIT_CYC);
                    state_d  = StTxInhibit;
                end
`endif
            end
            StRx: begin
                cnt_d = cnt_q + CntW'(1);
                if (fall) begin
                    cnt_d = '0;
                    if (bcnt_q == 4'd9) begin
                        // Stop bit: data+parity must carry odd parity
                        state_d = StIdle;
                        if (dat_f_q && (^rx_sh_q)) begin
                            rx_ok = 1'b1;
                        end else begin
                            set_err = 1'b1;
                        end
                    end else begin
                        rx_sh_d = {dat_f_q, rx_sh_q[8:1]};
                        bcnt_d  = bcnt_q + 4'd1;
                    end
                end else if (timeout) begin
                    set_err = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
`ifdef RELM_PS2_TX_EN
            StTxInhibit: begin
                if (cnt_q <= CntW'(1)) begin
                    // Request-to-send: pull data low as the clock is released
                    dat_oe_d = 1'b1;
                    clk_oe_d = 1'b0;
                    cnt_d    = '0;
                    bcnt_d   = '0;
                    state_d  = StTx;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StTx: begin
                cnt_d = cnt_q + CntW'(1);
                if (fall) begin
                    cnt_d    = '0;
                    dat_oe_d = ~tx_sh_q[0];
                    tx_sh_d  = {1'b0, tx_sh_q[9:1]};
                    bcnt_d   = bcnt_q + 4'd1;
                    if (bcnt_q == 4'd9) begin
                        state_d = StTxAck;
                    end
                end else if (timeout) begin
                    set_err  = 1'b1;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end
            end
            StTxAck: begin
                cnt_d = cnt_q + CntW'(1);
                if (fall) begin
                    set_err = dat_f_q;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (timeout) begin
                    set_err  = 1'b1;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            rx_sh_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            rx_sh_q <= rx_sh_d;
        end
    end

`ifdef RELM_PS2_TX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh_q  <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            tx_sh_q  <= tx_sh_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    assign ps2_clk_oe_out = clk_oe_q;
    assign ps2_dat_oe_out = dat_oe_q;
    assign io.push_retry  = (state_q != StIdle) | fall;
`else
    assign ps2_clk_oe_out = 1'b0;
    assign ps2_dat_oe_out = 1'b0;
    assign io.push_retry  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Scancode FIFO and sticky flags
    // ------------------------------------------------------------------
    logic [7:0]   mem [Depth];
    logic [WAF-1:0] wptr_q, rptr_q;
    logic [WAF:0] fcnt_q, fcnt_d;
    logic         empty, full, pop_en, wr_en, set_ovf;
    logic         err_q, err_d, ovf_q, ovf_d;

    assign empty   = (fcnt_q == '0);
    assign full    = (fcnt_q == (WAF+1)'(Depth));
    assign pop_en  = io.pop_d[WD] & ~empty;
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign wr_en   = rx_ok & (~full | pop_en);
    assign set_ovf = rx_ok & full & ~pop_en;
    assign fcnt_d  = fcnt_q + (WAF+1)'(wr_en) - (WAF+1)'(pop_en);

    always_comb begin
        err_d = err_q;
        ovf_d = ovf_q;
        if (io.pop_d[WD-1]) begin
            err_d = 1'b0;
            ovf_d = 1'b0;
        end
        if (set_err) begin
            err_d = 1'b1;
        end
        if (set_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + WAF'(1);
            end
            if (pop_en) begin
                rptr_q <= rptr_q + WAF'(1);
            end
            fcnt_q <= fcnt_d;
            err_q  <= err_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= rx_sh_q[7:0];
        end
    end

    assign io.pop_q = {empty, ovf_q, err_q, (WD-10)'(0), mem[rptr_q]};

`ifdef RELM_PS2_TX_EN
    logic unused_bits;
    assign unused_bits = ^{io.pop_d[WD-2:0], io.push_d[WD-1:8]};
`else
    logic unused_bits;
    assign unused_bits = ^{io.pop_d[WD-2:0], io.push_d};
`endif

endmodule

// File: tb/tb_relm_ps2_ctrl.sv
// Scoreboard bench for relm_ps2_ctrl: device model drives/receives PS/2 frames on open-drain lines.
module tb_relm_ps2_ctrl;

    localparam int unsigned WD     = 32;
    localparam int unsigned FILTER = 8;
    localparam int unsigned WAF    = 4;
    localparam int unsigned INH    = 50;
    localparam int unsigned TMO    = 600;
    localparam int unsigned HALF   = 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk_lo = 1'b0;
    logic dev_dat_lo = 1'b0;
    logic clk_oe, dat_oe;

    wire ps2_clk_line = ~(dev_clk_lo | clk_oe);
    wire ps2_dat_line = ~(dev_dat_lo | dat_oe);

    relm_ps2_ctrl_if #(.WD(WD)) bus ();

    relm_ps2_ctrl #(
        .WD         (WD),
        .FILTER     (FILTER),
        .WAF        (WAF),
        .INHIBIT_CYC(INH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ps2_clk_in    (ps2_clk_line),
        .ps2_dat_in    (ps2_dat_line),
        .ps2_clk_oe_out(clk_oe),
        .ps2_dat_oe_out(dat_oe),
        .io            (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device-to-host frame; nfall < 11 truncates the frame after that many clock pulses.
    task automatic dev_send(input logic [7:0] b, input bit bad_par, input int nfall);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nfall; i++) begin
            dev_dat_lo = ~f[i];
            cyc(HALF);
            dev_clk_lo = 1'b1;
            cyc(HALF);
            dev_clk_lo = 1'b0;
        end
        dev_dat_lo = 1'b0;
        cyc(2 * HALF);
    endtask

    task automatic pop(input bit clr);
        bus.pop_d = '0;
        bus.pop_d[WD] = 1'b1;
        bus.pop_d[WD-1] = clr;
        cyc(1);
        bus.pop_d = '0;
    endtask

    task automatic clear_flags();
        bus.pop_d = '0;
        bus.pop_d[WD-1] = 1'b1;
        cyc(1);
        bus.pop_d = '0;
    endtask

`ifdef RELM_PS2_TX_EN
    // Device side of a host-to-device transfer, starting the cycle after the push edge.
    task automatic dev_recv(input bit exp_par);
        int n;
        logic [9:0] got;
        n = 0;
        while (clk_oe && n < int'(INH) + 10) begin
            n++;
            cyc(1);
        end
        check("inhibit_len", n, INH);
        check("rts_dat_low", dat_oe, 1);
        check("push_retry_busy", bus.push_retry, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(HALF);
            dev_clk_lo = 1'b1;
            cyc(HALF);
            got[i] = ps2_dat_line;
            dev_clk_lo = 1'b0;
        end
        cyc(HALF / 2);
        dev_dat_lo = 1'b1;
        cyc(HALF / 2);
        dev_clk_lo = 1'b1;
        cyc(HALF);
        dev_clk_lo = 1'b0;
        dev_dat_lo = 1'b0;
        cyc(HALF);
        if (tx_exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_unexpected: got %0h, required none", got[7:0]);
        end else begin
            check("tx_byte", got[7:0], tx_exp_q.pop_front());
        end
        check("tx_parity", got[8], exp_par);
        check("tx_stop", got[9], 1);
    endtask
`endif

    // Monitor: every accepted pop is scored against the expected RX byte stream.
    always @(negedge clk) begin
        if (rst_n && bus.pop_d[WD] && !bus.pop_q[WD]) begin
            if (rx_exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_unexpected: got %0h, required none", bus.pop_q[7:0]);
            end else begin
                check("rx_byte", {24'b0, bus.pop_q[7:0]}, {24'b0, rx_exp_q.pop_front()});
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        bus.push_d = '0;
        bus.pop_d  = '0;
        cyc(5);
        check("rst_pop_hi", {8'b0, bus.pop_q[WD:8]}, {8'b0, 1'b1, 24'b0});
        check("rst_oe", {clk_oe, dat_oe}, 0);
        check("rst_push_retry", bus.push_retry, 0);
        rst_n = 1'b1;
        cyc(20);

        // Good frame
        rx_exp_q.push_back(8'h1C);
        dev_send(8'h1C, 1'b0, 11);
        check("rx1_nonempty", bus.pop_q[WD], 0);
        check("rx1_err", bus.pop_q[WD-2], 0);
        pop(1'b0);
        check("rx1_empty_after_pop", bus.pop_q[WD], 1);

        // Bad parity
        dev_send(8'h5A, 1'b1, 11);
        check("par_empty", bus.pop_q[WD], 1);
        check("par_err", bus.pop_q[WD-2], 1);
        pop(1'b1);
        check("par_err_cleared", bus.pop_q[WD-2], 0);

        // Overflow: 17 frames into 16 entries
        for (int i = 0; i < 17; i++) begin
            if (i < 16) rx_exp_q.push_back(8'(i));
            dev_send(8'(i), 1'b0, 11);
        end
        check("ovf_set", bus.pop_q[WD-1], 1);
        check("ovf_err", bus.pop_q[WD-2], 0);
        for (int i = 0; i < 16; i++) pop(1'b0);
        check("ovf_drained", bus.pop_q[WD], 1);
        pop(1'b0);
        check("pop_empty_noeffect", bus.pop_q[WD], 1);
        clear_flags();
        check("ovf_cleared", bus.pop_q[WD-1], 0);

        // Watchdog: frame abandoned after 4 falls
        dev_send(8'h1C, 1'b0, 4);
        cyc(TMO - 125);
        check("tmo_err_early", bus.pop_q[WD-2], 0);
        cyc(100);
        check("tmo_err_set", bus.pop_q[WD-2], 1);
        clear_flags();
        rx_exp_q.push_back(8'h1C);
        dev_send(8'h1C, 1'b0, 11);
        check("tmo_recover_nonempty", bus.pop_q[WD], 0);
        check("tmo_recover_err", bus.pop_q[WD-2], 0);
        pop(1'b0);

        // Short clock glitch with data low must not start a frame
        n = 0;
        dev_dat_lo = 1'b1;
        dev_clk_lo = 1'b1;
        cyc(3);
        dev_clk_lo = 1'b0;
        cyc(2);
        dev_dat_lo = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.push_retry) n++;
            cyc(1);
        end
        check("glitch_no_fall", n, 0);
        rx_exp_q.push_back(8'hE7);
        dev_send(8'hE7, 1'b0, 11);
        check("glitch_then_rx", bus.pop_q[WD], 0);
        check("glitch_then_err", bus.pop_q[WD-2], 0);
        pop(1'b0);

`ifdef RELM_PS2_TX_EN
        // Host-to-device transfer
        bus.push_d = '0;
        bus.push_d[WD] = 1'b1;
        bus.push_d[7:0] = 8'hFF;
        check("push1_retry", bus.push_retry, 0);
        tx_exp_q.push_back(8'hFF);
        cyc(1);
        bus.push_d = '0;
        check("push1_clk_oe", clk_oe, 1);
        dev_recv(1'b1);
        cyc(5);
        check("tx_ack_err", bus.pop_q[WD-2], 0);
        check("tx_done_retry", bus.push_retry, 0);

        // Second push accepted straight away, then reset during the transfer
        bus.push_d[WD] = 1'b1;
        bus.push_d[7:0] = 8'hA5;
        check("push2_retry", bus.push_retry, 0);
        cyc(1);
        bus.push_d = '0;
        check("push2_clk_oe", clk_oe, 1);
        n = 0;
        while (clk_oe && n < int'(INH) + 10) begin
            n++;
            cyc(1);
        end
        check("push2_start_bit", dat_oe, 1);
        #3 rst_n = 1'b0;
        #1 check("rst_async_release", {clk_oe, dat_oe}, 0);
`else
        bus.push_d = '0;
        bus.push_d[WD] = 1'b1;
        bus.push_d[7:0] = 8'hFF;
        check("notx_push_retry", bus.push_retry, 0);
        cyc(1);
        bus.push_d = '0;
        cyc(INH + 5);
        check("notx_oe", {clk_oe, dat_oe}, 0);
        check("notx_retry_after", bus.push_retry, 0);
        #3 rst_n = 1'b0;
        #1 check("rst_async_release", {clk_oe, dat_oe}, 0);
`endif
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        check("post_rst_empty", bus.pop_q[WD], 1);
        check("post_rst_flags", {bus.pop_q[WD-1], bus.pop_q[WD-2]}, 0);
        check("rx_leftover", rx_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
